// File: rtl/fifo_uart_drain_pkg.sv
// rtl/fifo_uart_drain_pkg.sv - UART framing constants, divisor helper and FSM state types
package fifo_uart_drain_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_REQ,
        DR_WAIT_MEM,
        DR_SEND
    } drain_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // sysclk cycles per UART bit, truncated; callers need a result of at least 2
    function automatic int calc_divisor(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_uart_tx.sv
// rtl/fifo_uart_drain_uart_tx.sv - 8N1 UART transmitter with start/busy/done handshake
module fifo_uart_drain_uart_tx
    import fifo_uart_drain_pkg::*;
#(
    parameter int DIVISOR = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int                 CNT_W    = $clog2(DIVISOR);
    localparam int                 IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t              state, state_nx;
    logic [CNT_W-1:0]       baud_cnt, cnt_nx;
    logic [IDX_W-1:0]       bit_idx, idx_nx;
    logic [DATA_BITS-1:0]   shift, shift_nx;
    logic                   tx_nx;
    logic                   bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);
    assign busy    = (state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= STOP_BIT;
        end else begin
            state    <= state_nx;
            baud_cnt <= cnt_nx;
            bit_idx  <= idx_nx;
            shift    <= shift_nx;
            tx       <= tx_nx;
        end
    end

    // tx_nx is the pin level for the state being entered, so the pin is a plain flop
    always_comb begin
        state_nx = state;
        cnt_nx   = baud_cnt + 1'b1;
        idx_nx   = bit_idx;
        shift_nx = shift;
        tx_nx    = tx;
        done     = 1'b0;
        case (state)
            TX_IDLE: begin
                cnt_nx = '0;
                tx_nx  = STOP_BIT;
                if (start) begin
                    state_nx = TX_START;
                    shift_nx = data;
                    tx_nx    = START_BIT;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_nx = TX_DATA;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    tx_nx    = shift[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_nx   = '0;
                    shift_nx = shift >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_nx = TX_STOP;
                        tx_nx    = STOP_BIT;
                    end else begin
                        idx_nx = bit_idx + 1'b1;
                        tx_nx  = shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_nx = TX_IDLE;
                    cnt_nx   = '0;
                    done     = 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pulls bytes from the external-memory FIFO and sends them as UART frames
module fifo_uart_drain
    import fifo_uart_drain_pkg::*;
#(
    parameter int CLK_FREQ = 60_000_000,
    parameter int BAUDRATE = 115_200,
    parameter int BITS     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [BITS-1:0] fifo_rd_data,
    input  logic            fifo_completed,
    output logic            tx,
    output logic            busy,
    output logic [15:0]     sent_count
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUDRATE);

    drain_state_t state, state_nx;
    logic         mem_done;
    logic         tx_busy;
    logic         tx_done;

    // completions outside WAIT_MEM never reach the transmitter
    assign mem_done   = (state == DR_WAIT_MEM) && fifo_completed;
    assign fifo_rd_en = (state == DR_REQ);
    assign busy       = (state != DR_IDLE) || tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DR_IDLE;
            sent_count <= '0;
        end else begin
            state <= state_nx;
            if (state == DR_SEND && tx_done) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            DR_IDLE:     if (enable && !fifo_empty) state_nx = DR_REQ;
            DR_REQ:      state_nx = DR_WAIT_MEM;
            DR_WAIT_MEM: if (fifo_completed) state_nx = DR_SEND;
            DR_SEND:     if (tx_done) state_nx = DR_IDLE;
            default:     state_nx = DR_IDLE;
        endcase
    end

    fifo_uart_drain_uart_tx #(
        .DIVISOR (DIVISOR)
    ) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mem_done),
        .data  (fifo_rd_data),
        .busy  (tx_busy),
        .done  (tx_done),
        .tx    (tx)
    );

endmodule
